// File: rtl/dds_meas_pkg.sv
// Shared types and default constants for the DDS sample-stream measurement blocks.
// Sample width matches the DDS Magnitude output.
package dds_meas_pkg;

    localparam int unsigned SAMPLE_W_DEF = 8;
    localparam int unsigned CNT_W_DEF    = 16;
    localparam int unsigned MID_DEF      = 128;
    localparam int unsigned HYST_DEF     = 4;

    typedef enum logic [1:0] {
        S_INIT,
        S_LOW,
        S_HIGH
    } cross_state_e;

endpackage

// File: rtl/crossing_detector.sv
// Hysteresis comparator and 3-state side tracker for midscale crossings.
// Emits a one-cycle rise strobe on the accepted sample that crosses upward out of S_LOW.
module crossing_detector
    import dds_meas_pkg::*;
#(
    parameter int unsigned SAMPLE_W = SAMPLE_W_DEF,
    parameter int unsigned MID      = MID_DEF,
    parameter int unsigned HYST     = HYST_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [SAMPLE_W-1:0] sample,
    input  logic                sample_valid,
    input  logic                restart,
    output logic                rise
);

    // One extra bit so MID+HYST never wraps for a full-scale threshold.
    localparam logic [SAMPLE_W:0] HI_TH = (SAMPLE_W + 1)'(MID + HYST);
    localparam logic [SAMPLE_W:0] LO_TH = (SAMPLE_W + 1)'(MID - HYST);

    cross_state_e state_q, state_d;
    logic         above, below;

    assign above = {1'b0, sample} >= HI_TH;
    assign below = {1'b0, sample} <= LO_TH;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_INIT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (restart) begin
            state_d = S_INIT;
        end else if (sample_valid) begin
            unique case (state_q)
                S_INIT: begin
                    if (above) begin
                        state_d = S_HIGH;
                    end else if (below) begin
                        state_d = S_LOW;
                    end
                end
                S_LOW:   if (above) state_d = S_HIGH;
                S_HIGH:  if (below) state_d = S_LOW;
                default: state_d = S_INIT;
            endcase
        end
    end

    always_comb begin
        rise = sample_valid && (state_q == S_LOW) && above;
    end

endmodule

// File: rtl/dds_period_meter.sv
// Measures period (in accepted samples) and min/max per waveform cycle of the DDS output.
// Optional PERIOD_AVG_EN: report a sliding 4-period average instead of the raw period.
module dds_period_meter
    import dds_meas_pkg::*;
#(
    parameter int unsigned SAMPLE_W = SAMPLE_W_DEF,
    parameter int unsigned CNT_W    = CNT_W_DEF,
    parameter int unsigned MID      = MID_DEF,
    parameter int unsigned HYST     = HYST_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [SAMPLE_W-1:0] sample_in,
    input  logic                sample_valid,
    output logic [CNT_W-1:0]    period,
    output logic [SAMPLE_W-1:0] peak_max,
    output logic [SAMPLE_W-1:0] peak_min,
    output logic                meas_valid,
    output logic                locked,
    output logic                overflow
);

    // Largest count that may still be incremented: period cnt+1 always fits in CNT_W.
    localparam logic [CNT_W-1:0] CNT_LIMIT = {{(CNT_W - 1){1'b1}}, 1'b0};

    logic [CNT_W-1:0]    cnt_q;
    logic [SAMPLE_W-1:0] min_q, max_q;
    logic                locked_q, overflow_q, meas_valid_q;
    logic [CNT_W-1:0]    period_q;
    logic [SAMPLE_W-1:0] peak_max_q, peak_min_q;

    logic                rise, timeout, report_raw, report;
    logic [CNT_W-1:0]    raw_period, report_period;
    logic [SAMPLE_W-1:0] cyc_max, cyc_min;

    crossing_detector #(
        .SAMPLE_W (SAMPLE_W),
        .MID      (MID),
        .HYST     (HYST)
    ) u_crossing_detector (
        .clk          (clk),
        .rst          (rst),
        .sample       (sample_in),
        .sample_valid (sample_valid),
        .restart      (timeout),
        .rise         (rise)
    );

    always_comb begin
        raw_period = cnt_q + CNT_W'(1);
        report_raw = rise && locked_q;
        timeout    = sample_valid && locked_q && !rise && (cnt_q == CNT_LIMIT);
        cyc_max    = (sample_in > max_q) ? sample_in : max_q;
        cyc_min    = (sample_in < min_q) ? sample_in : min_q;
    end

`ifdef PERIOD_AVG_EN
    logic [CNT_W-1:0] hist_q [4];
    logic [2:0]       fill_q;
    logic [CNT_W+1:0] sum_new;

    // Sum of the three newest stored periods plus the one being completed now.
    always_comb begin
        sum_new = {2'b00, hist_q[1]} + {2'b00, hist_q[2]} + {2'b00, hist_q[3]}
                + {2'b00, raw_period};
        report        = report_raw && (fill_q >= 3'd3);
        report_period = sum_new[CNT_W+1:2];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) hist_q[i] <= '0;
            fill_q <= '0;
        end else if (timeout) begin
            for (int i = 0; i < 4; i++) hist_q[i] <= '0;
            fill_q <= '0;
        end else if (report_raw) begin
            hist_q[0] <= hist_q[1];
            hist_q[1] <= hist_q[2];
            hist_q[2] <= hist_q[3];
            hist_q[3] <= raw_period;
            if (fill_q < 3'd4) fill_q <= fill_q + 3'd1;
        end
    end
`else
    always_comb begin
        report        = report_raw;
        report_period = raw_period;
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q        <= '0;
            min_q        <= '0;
            max_q        <= '0;
            locked_q     <= 1'b0;
            overflow_q   <= 1'b0;
            meas_valid_q <= 1'b0;
            period_q     <= '0;
            peak_max_q   <= '0;
            peak_min_q   <= '0;
        end else begin
            meas_valid_q <= report;
            if (sample_valid) begin
                if (rise) begin
                    if (report) begin
                        period_q   <= report_period;
                        peak_max_q <= cyc_max;
                        peak_min_q <= cyc_min;
                        overflow_q <= 1'b0;
                    end
                    locked_q <= 1'b1;
                    cnt_q    <= '0;
                    max_q    <= sample_in;
                    min_q    <= sample_in;
                end else if (timeout) begin
                    overflow_q <= 1'b1;
                    locked_q   <= 1'b0;
                    cnt_q      <= '0;
                end else if (locked_q) begin
                    cnt_q <= raw_period;
                    max_q <= cyc_max;
                    min_q <= cyc_min;
                end
            end
        end
    end

    assign period     = period_q;
    assign peak_max   = peak_max_q;
    assign peak_min   = peak_min_q;
    assign meas_valid = meas_valid_q;
    assign locked     = locked_q;
    assign overflow   = overflow_q;

endmodule
